// File: rtl/dmem_master_pkg.sv
// Shared definitions for the data-RAM initiator: op codes, RAM control
// levels, FSM encoding and the request legality helpers.
package dmem_master_pkg;

  // Default RAM depth (log2 of words); must track the data-memory size.
  localparam int MEM_LOG2_DEF = 17;
  localparam int DMEM_DEPTH   = 1 << MEM_LOG2_DEF;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } mem_op_e;

  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } dmem_state_e;

  // True for SB/SH/SW.
  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halfwords need an even offset, words need offset 0; bytes always fit.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      OP_LW, OP_SW:         mis = (off != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane logic for the data-RAM port. The store side turns op/offset into
// a byte select and a lane-replicated write word; the load side undoes the
// RAM's byte reversal, picks the addressed lane and extends it.
module dmem_lane_unit
  import dmem_master_pkg::*;
(
  input  logic [2:0]  st_op_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] unrev_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // The RAM hands back lane [31:24] at [7:0]; restore write-lane order.
  assign unrev_s = {rdata_i[7:0], rdata_i[15:8], rdata_i[23:16], rdata_i[31:24]};

  // Byte select: offset 0 is the most significant lane (big-endian).
  always_comb begin
    sel_o = 4'b0000;
    case (st_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        case (st_off_i)
          2'd0:    sel_o = 4'b1000;
          2'd1:    sel_o = 4'b0100;
          2'd2:    sel_o = 4'b0010;
          default: sel_o = 4'b0001;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: begin
        if (st_off_i[1]) begin
          sel_o = 4'b0011;
        end else begin
          sel_o = 4'b1100;
        end
      end
      default: sel_o = 4'b1111;
    endcase
  end

  // Replicate narrow store data across lanes so sel alone picks the target.
  always_comb begin
    wdata_o = st_wdata_i;
    case (st_op_i)
      OP_SB:   wdata_o = {4{st_wdata_i[7:0]}};
      OP_SH:   wdata_o = {2{st_wdata_i[15:0]}};
      default: wdata_o = st_wdata_i;
    endcase
  end

  // Lane extraction from the un-reversed word.
  always_comb begin
    byte_s = unrev_s[7:0];
    case (ld_off_i)
      2'd0:    byte_s = unrev_s[31:24];
      2'd1:    byte_s = unrev_s[23:16];
      2'd2:    byte_s = unrev_s[15:8];
      default: byte_s = unrev_s[7:0];
    endcase
    if (ld_off_i[1]) begin
      half_s = unrev_s[15:0];
    end else begin
      half_s = unrev_s[31:16];
    end
  end

  // Sign- or zero-extension of the selected lane.
  always_comb begin
    ld_data_o = unrev_s;
    case (ld_op_i)
      OP_LB:   ld_data_o = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ld_data_o = {24'h00_0000, byte_s};
      OP_LH:   ld_data_o = {{16{half_s[15]}}, half_s};
      OP_LHU:  ld_data_o = {16'h0000, half_s};
      default: ld_data_o = unrev_s;
    endcase
  end

endmodule

// File: rtl/dmem_master.sv
// Data-RAM initiator for the MEM stage. Accepts one load/store at a time,
// rejects misaligned or out-of-range requests without touching the RAM,
// drives one ISSUE cycle to the RAM, and for loads captures the registered
// read word one cycle later. All outputs are registered.
module dmem_master
  import dmem_master_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MEM_LOG2 = MEM_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_data,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i
);

  dmem_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;

  logic              accept_s;
  logic              oor_s;
  logic              req_err_s;
  logic [3:0]        enc_sel_s;
  logic [31:0]       enc_wdata_s;
  logic [31:0]       ld_data_s;

  assign accept_s  = req_valid & ready_q;
  assign oor_s     = |req_addr[ADDR_W-1:MEM_LOG2+2];
  assign req_err_s = oor_s | is_misaligned(req_op, req_addr[1:0]);

  // Encoder works on the live request (used only at accept); decoder on latched fields.
  dmem_lane_unit u_lane (
    .st_op_i    (req_op),
    .st_off_i   (req_addr[1:0]),
    .st_wdata_i (req_wdata),
    .sel_o      (enc_sel_s),
    .wdata_o    (enc_wdata_s),
    .ld_op_i    (op_q),
    .ld_off_i   (off_q),
    .rdata_i    (ram_data_i),
    .ld_data_o  (ld_data_s)
  );

  // Next-state and registered-output decode; ce/we are only ever set for the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = ZERO_WORD;
    ce_d        = CHIP_DISABLE;
    we_d        = WRITE_DISABLE;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    off_d       = off_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            ce_d    = CHIP_ENABLE;
            we_d    = is_store(req_op) ? WRITE_ENABLE : WRITE_DISABLE;
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            sel_d   = enc_sel_s;
            op_d    = req_op;
            off_d   = req_addr[1:0];
            if (is_store(req_op)) begin
              wdata_d = enc_wdata_s;
            end else begin
              wdata_d = wdata_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (is_store(op_q)) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = ld_data_s;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= ZERO_WORD;
      ce_q        <= CHIP_DISABLE;
      we_q        <= WRITE_DISABLE;
      addr_q      <= '0;
      sel_q       <= 4'b0000;
      wdata_q     <= ZERO_WORD;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      off_q       <= off_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign ram_ce_o   = ce_q;
  assign ram_we_o   = we_q;
  assign ram_addr_o = addr_q;
  assign ram_sel_o  = sel_q;
  assign ram_data_o = wdata_q;

endmodule

// File: tb/tb_dmem_master.sv
// Self-checking bench for dmem_master: a byte-addressed big-endian memory
// model predicts every response and every RAM-port cycle; a behavioural RAM
// (byte-reversed read return) sits on the port.
`timescale 1ns/1ps
module tb_dmem_master;

  localparam int ADDR_W   = 32;
  localparam int MEM_LOG2 = 17;
  localparam int NW       = 8192;

  localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011;
  localparam logic [2:0] LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_master #(.ADDR_W(ADDR_W), .MEM_LOG2(MEM_LOG2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_rdata)
  );

  // ---------------- behavioural RAM (256 words, lanes as written, read reversed)
  logic [31:0] ram [0:255] = '{default: 32'h0};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (sel[l]) r[l*8 +: 8] = nw[l*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o)
      ram[ram_addr_o[9:2]] <= merge(ram[ram_addr_o[9:2]], ram_data_o, ram_sel_o);
    else if (ram_ce_o) begin
      ram_rdata <= {ram[ram_addr_o[9:2]][7:0], ram[ram_addr_o[9:2]][15:8],
                    ram[ram_addr_o[9:2]][23:16], ram[ram_addr_o[9:2]][31:24]};
    end
  end

  // ---------------- reference model
  logic [7:0] ref_mem [0:1023] = '{default: 8'h00};
  int edge_n = 0;
  int next_free = 0;
  bit chk_en = 1'b0;
  bit          e_rv [0:NW-1];
  bit          e_err[0:NW-1];
  logic [31:0] e_data[0:NW-1];
  bit          e_ce [0:NW-1];
  bit          e_we [0:NW-1];
  bit          e_busy[0:NW-1];
  logic [31:0] e_addr[0:NW-1];
  logic [3:0]  e_sel[0:NW-1];
  logic [31:0] e_wd [0:NW-1];

  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (window %0d): got 0x%08h, expected 0x%08h", name, edge_n, act, exp);
    end
  endfunction

  function automatic int op_size(input logic [2:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit op_store(input logic [2:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic bit model_err(input logic [2:0] op, input logic [31:0] a);
    return ((a % op_size(op)) != 0) || ((a >> (MEM_LOG2 + 2)) != 0);
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] op, input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    for (int i = 0; i < op_size(op); i++) s[3 - ((a + i) % 4)] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    if (op == SB) return {4{wd[7:0]}};
    if (op == SH) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = op_size(op);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = {v[23:0], ref_mem[(a + i) % 1024]};
    if ((op == LB || op == LH) && v[n*8-1]) v = v | (32'hFFFF_FFFF << (n*8));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = op_size(op);
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 1024] = wd[(n-1-i)*8 +: 8];
  endtask

  // Record the consequences of an accept decided in window k (accept edge k+1).
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, input int k);
    if (model_err(op, a)) begin
      e_rv[k+1] = 1'b1; e_err[k+1] = 1'b1; e_data[k+1] = 32'h0;
      next_free = k + 1;
    end else begin
      e_ce[k+1] = 1'b1; e_we[k+1] = op_store(op); e_busy[k+1] = 1'b1;
      e_addr[k+1] = {a[31:2], 2'b00}; e_sel[k+1] = model_sel(op, a);
      e_wd[k+1] = model_wdata(op, wd);
      if (op_store(op)) begin
        e_rv[k+2] = 1'b1; e_data[k+2] = 32'h0;
        model_store(op, a, wd);
        next_free = k + 2;
      end else begin
        e_busy[k+2] = 1'b1;
        e_rv[k+3] = 1'b1; e_data[k+3] = model_load(op, a);
        next_free = k + 3;
      end
    end
  endtask

  // Present a request at a falling edge and hold it until the model says it is taken.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, output int acc);
    int waited;
    waited = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    while (edge_n < next_free && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (edge_n < next_free) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout: got waited=%0d, expected < 10", waited);
    end
    acc = edge_n;
    accept(op, a, wd, acc);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Per-cycle compare of all outputs against the model schedule.
  always @(negedge clk) begin
    int k;
    k = edge_n;
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_ce", 32'(ram_ce_o), 32'h0);
      chk("rst_we", 32'(ram_we_o), 32'h0);
      chk("rst_addr", ram_addr_o, 32'h0);
      chk("rst_sel", 32'(ram_sel_o), 32'h0);
      chk("rst_wdata", ram_data_o, 32'h0);
    end else if (chk_en && k < NW) begin
      chk("req_ready", 32'(req_ready), 32'(!e_busy[k]));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[k]));
      chk("rsp_err", 32'(rsp_err), 32'(e_err[k]));
      if (e_rv[k]) chk("rsp_data", rsp_data, e_data[k]);
      chk("ram_ce", 32'(ram_ce_o), 32'(e_ce[k]));
      chk("ram_we", 32'(ram_we_o), 32'(e_we[k]));
      if (e_ce[k]) begin
        chk("ram_addr", ram_addr_o, e_addr[k]);
        chk("ram_sel", 32'(ram_sel_o), 32'(e_sel[k]));
        if (e_we[k]) chk("ram_wdata", ram_data_o, e_wd[k]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k2;
    logic [7:0] saved [0:3];
    for (int i = 0; i < NW; i++) begin
      e_rv[i] = 1'b0; e_err[i] = 1'b0; e_data[i] = 32'h0; e_ce[i] = 1'b0;
      e_we[i] = 1'b0; e_busy[i] = 1'b0; e_addr[i] = 32'h0; e_sel[i] = 4'h0; e_wd[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'h1);
    next_free = edge_n;
    chk_en = 1'b1;

    // Word store then load, with a literal latency check.
    chk("pin_sel_lw", 32'(model_sel(LW, 32'h10)), 32'h0000_000F);
    issue(SW, 32'h10, 32'h1122_3344, k1);
    chk("pin_lw10", model_load(LW, 32'h10), 32'h1122_3344);
    issue(LW, 32'h10, 32'hFFFF_FFFF, k1);
    @(negedge clk);
    chk("lw_not_early", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("lw_3_edges_valid", 32'(rsp_valid), 32'h1);
    chk("lw_3_edges_data", rsp_data, 32'h1122_3344);

    // Byte store / loads.
    chk("pin_sel_sb21", 32'(model_sel(SB, 32'h21)), 32'h0000_0004);
    chk("pin_wd_sb", model_wdata(SB, 32'h0000_00A5), 32'hA5A5_A5A5);
    issue(SB, 32'h21, 32'h0000_00A5, k1);
    chk("pin_lb21", model_load(LB, 32'h21), 32'hFFFF_FFA5);
    chk("pin_lbu21", model_load(LBU, 32'h21), 32'h0000_00A5);
    issue(LB, 32'h21, 32'h0, k1);
    issue(LBU, 32'h21, 32'h0, k1);

    // Halfword store / loads.
    chk("pin_sel_sh32", 32'(model_sel(SH, 32'h32)), 32'h0000_0003);
    issue(SH, 32'h32, 32'h0000_8001, k1);
    chk("pin_lh32", model_load(LH, 32'h32), 32'hFFFF_8001);
    chk("pin_lhu32", model_load(LHU, 32'h32), 32'h0000_8001);
    chk("pin_lw30", model_load(LW, 32'h30), 32'h0000_8001);
    issue(LH, 32'h32, 32'h0, k1);
    issue(LHU, 32'h32, 32'h0, k1);
    issue(LW, 32'h30, 32'h0, k1);

    // Rejected requests.
    chk("pin_err_lw13", 32'(model_err(LW, 32'h13)), 32'h1);
    chk("pin_err_oor", 32'(model_err(LW, 32'h1 << (MEM_LOG2 + 2))), 32'h1);
    issue(LW, 32'h13, 32'h0, k1);
    issue(LH, 32'h11, 32'h0, k1);
    issue(SW, 32'h02, 32'h0, k1);
    issue(LW, 32'h1 << (MEM_LOG2 + 2), 32'h0, k1);

    // Back-to-back spacing.
    issue(LW, 32'h10, 32'h0, k1);
    issue(LW, 32'h30, 32'h0, k2);
    chk("ld_ld_spacing", 32'(k2 - k1), 32'h3);
    issue(SW, 32'h44, 32'hCAFE_F00D, k1);
    issue(SW, 32'h48, 32'h0BAD_BEEF, k2);
    chk("st_st_spacing", 32'(k2 - k1), 32'h2);

    // Reset during the ISSUE cycle of a store.
    for (int i = 0; i < 4; i++) saved[i] = ref_mem[32'h80 + i];
    issue(SW, 32'h80, 32'hDEAD_BEEF, k1);
    #1;
    rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("abort_ce", 32'(ram_ce_o), 32'h0);
    chk("abort_we", 32'(ram_we_o), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < 4; i++) ref_mem[32'h80 + i] = saved[i];
    for (int i = edge_n; i < edge_n + 6; i++) begin
      e_rv[i] = 1'b0; e_err[i] = 1'b0; e_ce[i] = 1'b0; e_we[i] = 1'b0; e_busy[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(req_ready), 32'h1);
    next_free = edge_n;
    chk_en = 1'b1;
    chk("pin_lw80_unchanged", model_load(LW, 32'h80), 32'h0);
    issue(LW, 32'h80, 32'h0, k1);

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] wd;
      op = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(MEM_LOG2 + 2, 31));
      wd = $urandom;
      issue(op, a, wd, k1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
